mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage: the producer side of the mem_wd/mem_wreg/mem_wdata interface feeding mem_wb.
//  Passes ALU results through unchanged. Executes loads and stores on a req/ack data-memory bus.
//  Stalls the pipeline (stall_req) while an access is outstanding.
//  Sign- or zero-extends load data. Flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT  16  max BUSY cycles without dmem_ack before abort (1..255)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  ex_valid     in   1   EX/MEM holds a valid instruction
//  ex_wd        in   5   destination register index
//  ex_wreg      in   1   instruction writes a register
//  ex_wdata     in   32  ALU result (pass-through value)
//  ex_mem_op    in   4   0 none,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW; 9-15 treated as none
//  ex_mem_addr  in   32  byte address of the access
//  ex_reg2      in   32  store data (low bits used for SB/SH)
//  mem_wd       out  5   to mem_wb: destination index
//  mem_wreg     out  1   to mem_wb: write enable
//  mem_wdata    out  32  to mem_wb: write data
//  stall_req    out  1   hold IF/ID/EX and EX/MEM this cycle
//  mem_err      out  1   one-cycle pulse: misaligned access or timeout
//  dmem_req     out  1   bus request (registered)
//  dmem_we      out  1   1 store, 0 load (registered)
//  dmem_addr    out  32  word-aligned address {addr[31:2],2'b00} (registered)
//  dmem_be      out  4   byte enables, bit i = byte lane i (registered)
//  dmem_wdata   out  32  store data replicated into lanes (registered)
//  dmem_ack     in   1   bus completes the access this cycle
//  dmem_rdata   in   32  load data, valid when dmem_ack=1
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; dmem_req/we/addr/be/wdata=0; mem_wd/wreg/wdata=0, stall_req=0, mem_err=0 while rst=1.
//  FSM IDLE/BUSY. mem_* and stall_req are combinational from state, inputs and latched regs.
//  IDLE, !ex_valid: mem_wreg=0, mem_wd=0, mem_wdata=0, stall_req=0.
//  IDLE, ex_valid, op=none: mem_wd=ex_wd, mem_wreg=ex_wreg, mem_wdata=ex_wdata, stall_req=0. Zero latency.
//  IDLE, ex_valid, mem op, misaligned:
//   - misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0
//   - mem_err=1 for that cycle; mem_wreg=0; no bus request; stay IDLE; stall_req=0
//  IDLE, ex_valid, aligned mem op:
//   - stall_req=1 and mem_wreg=0 this cycle
//   - latch wd, op, addr[1:0]; at the edge load dmem_* and set dmem_req=1, cnt=0; enter BUSY
//  Byte enables: B 4'b0001<<addr[1:0]; H addr[1]?4'b1100:4'b0011; W 4'b1111.
//  Store data: SB {4{reg2[7:0]}}; SH {2{reg2[15:0]}}; SW reg2.
//  BUSY, dmem_ack=0:
//   - stall_req=1, mem_wreg=0; dmem_* held stable; cnt+=1
//   - when cnt reaches TIMEOUT-1 with no ack: mem_err=1, stall_req=0, mem_wreg=0; dmem_req=0 next edge; go IDLE
//  BUSY, dmem_ack=1 (ack wins over timeout in the same cycle):
//   - stall_req=0; dmem_req=0 at the edge; go IDLE
//   - load: mem_wreg=1, mem_wd=latched wd, mem_wdata=extended lane
//   - store: mem_wreg=0
//  Load extension:
//   - byte lane = rdata[8*a+7:8*a], a = latched addr[1:0]
//   - half lane = rdata[16*a1+15:16*a1], a1 = latched addr[1]
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW uses rdata unchanged
//  The pipeline advances at the ack edge, so the cycle after IDLE sees the next instruction. No double issue.
//  ex_* inputs are ignored in BUSY; only latched copies are used.
//  dmem_ack in IDLE is ignored.
//  Reset mid-BUSY: dmem_req=0 after the reset edge, FSM to IDLE; the outstanding access is dropped.
//  Only one access is outstanding at a time; dmem_req never deasserts before ack, timeout or reset.
// TESTING
//  op=none, ex_wd=5, ex_wreg=1, ex_wdata=32'h1234 -> same cycle mem_wd=5, mem_wreg=1, mem_wdata=32'h1234, stall_req=0.
//  LB addr=32'h103, ack after 2 cycles, rdata=32'h80FF_FF00 -> dmem_be=4'b1000, stall_req=1 for 3 cycles, then mem_wdata=32'hFFFF_FF80, mem_wreg=1.
//  LHU addr=32'h102, ack at the first BUSY cycle, rdata=32'hBEEF_0000 -> dmem_be=4'b1100, mem_wdata=32'h0000_BEEF.
//  SB addr=32'h201, reg2=32'hAB -> dmem_we=1, dmem_addr=32'h200, be=4'b0010, wdata=32'hABAB_ABAB; on ack mem_wreg=0.
//  LW addr=32'h102 -> mem_err pulse, dmem_req stays 0, stall_req=0. LW aligned, no ack for TIMEOUT=16 cycles -> mem_err, return to IDLE.
//  rst=1 during BUSY -> next cycle dmem_req=0, stall_req=0, mem_wreg=0; a later ack is ignored.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage. ALU results pass straight through to mem_wb. Loads and
// stores go out on a registered req/ack data bus, and the pipeline is stalled
// while an access is outstanding. Load data is sign- or zero-extended.
// Misaligned accesses and bus timeouts raise a one-cycle mem_err pulse.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        stall_req,
  output logic        mem_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [0:0]  state_r;
  logic [7:0]  cnt_r;
  logic [4:0]  wd_r;
  logic [3:0]  op_r;
  logic [1:0]  alo_r;

  logic        is_load_s;
  logic        is_store_s;
  logic        is_mem_s;
  logic        misalign_s;
  logic        issue_s;
  logic        finish_s;
  logic [3:0]  be_s;
  logic [31:0] bwd_s;

  // Select the addressed lane of the returned word and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [3:0] op,
                                              input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Decode the incoming op: access kind, alignment, byte enables, store lanes.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    misalign_s = 1'b0;
    be_s       = 4'b0000;
    bwd_s      = ex_reg2;
    case (ex_mem_op)
      OP_LB, OP_LBU: begin
        is_load_s = 1'b1;
        be_s      = 4'b0001 << ex_mem_addr[1:0];
      end
      OP_LH, OP_LHU: begin
        is_load_s  = 1'b1;
        be_s       = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
        misalign_s = ex_mem_addr[0];
      end
      OP_LW: begin
        is_load_s  = 1'b1;
        be_s       = 4'b1111;
        misalign_s = |ex_mem_addr[1:0];
      end
      OP_SB: begin
        is_store_s = 1'b1;
        be_s       = 4'b0001 << ex_mem_addr[1:0];
        bwd_s      = {4{ex_reg2[7:0]}};
      end
      OP_SH: begin
        is_store_s = 1'b1;
        be_s       = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
        bwd_s      = {2{ex_reg2[15:0]}};
        misalign_s = ex_mem_addr[0];
      end
      OP_SW: begin
        is_store_s = 1'b1;
        be_s       = 4'b1111;
        misalign_s = |ex_mem_addr[1:0];
      end
      default: begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
      end
    endcase
  end

  assign is_mem_s = is_load_s | is_store_s;

  // Writeback, stall and error outputs from the current state and inputs.
  always_comb begin
    mem_wd    = 5'd0;
    mem_wreg  = 1'b0;
    mem_wdata = 32'd0;
    stall_req = 1'b0;
    mem_err   = 1'b0;
    issue_s   = 1'b0;
    finish_s  = 1'b0;
    if (rst) begin
      issue_s  = 1'b0;
      finish_s = 1'b0;
    end else if (state_r == IDLE) begin
      if (!ex_valid) begin
        issue_s = 1'b0;
      end else if (!is_mem_s) begin
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
      end else if (misalign_s) begin
        mem_err = 1'b1;
      end else begin
        stall_req = 1'b1;
        issue_s   = 1'b1;
      end
    end else begin
      if (dmem_ack) begin
        // Ack takes priority over a timeout landing in the same cycle.
        finish_s = 1'b1;
        if (!dmem_we) begin
          mem_wreg  = 1'b1;
          mem_wd    = wd_r;
          mem_wdata = extend_load(op_r, alo_r, dmem_rdata);
        end else begin
          mem_wreg = 1'b0;
        end
      end else if (cnt_r == CNT_LAST) begin
        finish_s = 1'b1;
        mem_err  = 1'b1;
      end else begin
        stall_req = 1'b1;
      end
    end
  end

  // FSM, timeout counter, latched access info and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      wd_r       <= 5'd0;
      op_r       <= 4'd0;
      alo_r      <= 2'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
    end else if (state_r == IDLE) begin
      if (issue_s) begin
        state_r    <= BUSY;
        cnt_r      <= 8'd0;
        wd_r       <= ex_wd;
        op_r       <= ex_mem_op;
        alo_r      <= ex_mem_addr[1:0];
        dmem_req   <= 1'b1;
        dmem_we    <= is_store_s;
        dmem_addr  <= {ex_mem_addr[31:2], 2'b00};
        dmem_be    <= be_s;
        dmem_wdata <= bwd_s;
      end else begin
        state_r <= IDLE;
      end
    end else begin
      if (finish_s) begin
        state_r  <= IDLE;
        dmem_req <= 1'b0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

endmodule
